// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and widths for the I2C target register window
// Protocol state encoding and byte/address widths used by the target and its bus interface.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - pin and register-window signals of the I2C target
// The slave modport is the target's view; master is the board/user-logic view.
interface i2c_target_regs_if
  import i2c_pkg::*;
#(
  parameter int PW = 4
);

  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic [PW-1:0]         reg_ptr;
  logic                  wr_stb;
  logic [I2C_BYTE_W-1:0] wr_data;
  logic                  rd_stb;
  logic [I2C_BYTE_W-1:0] rd_data;
  logic                  start_det;
  logic                  stop_det;
  logic                  busy;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_oe, reg_ptr, wr_stb, wr_data, rd_stb, start_det, stop_det, busy
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_oe, reg_ptr, wr_stb, wr_data, rd_stb, start_det, stop_det, busy
  );

endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop synchroniser plus saturating glitch filter for one bus line
// A new level is accepted only after FILTER_LEN consecutive equal synchronised samples.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample that agrees with the accepted level restarts the qualification run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with pointer-addressed byte register window
// Decodes START/STOP, matches TARGET_ADDR, and streams writes/reads with pointer auto-increment.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
  parameter int                    NUM_REGS    = 16,
  parameter int                    FILTER_LEN  = 4
) (
  input  logic                clk100,
  input  logic                reset_n,
  i2c_target_regs_if.slave    bus
);

  localparam int            PW       = $clog2(NUM_REGS);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REGS - 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_state_t            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [PW-1:0]         reg_ptr_q, reg_ptr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [I2C_BYTE_W-1:0] wr_data_q, wr_data_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  rd_cap_q, rd_cap_d;
  logic                  start_det_q, start_det_d;
  logic                  stop_det_q, stop_det_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic [I2C_BYTE_W-1:0] byte_v;
  logic [PW-1:0]         ptr_next;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i   (clk100),
    .rst_ni  (reset_n),
    .pin_i   (bus.scl_i),
    .level_o (scl_f),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i   (clk100),
    .rst_ni  (reset_n),
    .pin_i   (bus.sda_i),
    .level_o (sda_f),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_ev = sda_fall & scl_f;
  assign stop_ev  = sda_rise & scl_f;
  assign ptr_next = (reg_ptr_q == PTR_LAST) ? '0 : reg_ptr_q + 1'b1;

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reg_ptr_q   <= '0;
      sda_oe_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_data_q   <= '0;
      rd_stb_q    <= 1'b0;
      rd_cap_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_ptr_q   <= reg_ptr_d;
      sda_oe_q    <= sda_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_data_q   <= wr_data_d;
      rd_stb_q    <= rd_stb_d;
      rd_cap_q    <= rd_cap_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
    end
  end

  // Bits enter on filtered SCL rise; SDA drive only moves after a filtered SCL fall.
  // In ACK states bit_cnt 8 means "ACK not yet driven", 9 means "ACK clock in progress".
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_ptr_d   = reg_ptr_q;
    sda_oe_d    = sda_oe_q;
    wr_stb_d    = 1'b0;
    wr_data_d   = wr_data_q;
    rd_stb_d    = 1'b0;
    rd_cap_d    = rd_stb_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    busy_d      = busy_q;
    ack_d       = ack_q;
    byte_v      = {shift_q[I2C_BYTE_W-2:0], sda_f};

    if (start_ev) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      rd_cap_d    = 1'b0;
      start_det_d = 1'b1;
      busy_d      = 1'b1;
    end else if (stop_ev) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      rd_cap_d   = 1'b0;
      stop_det_d = 1'b1;
      busy_d     = 1'b0;
    end else begin
      // User logic answers rd_stb one cycle later; the MSB goes straight onto the pin.
      if (rd_cap_q) begin
        shift_d  = bus.rd_data;
        sda_oe_d = ~bus.rd_data[I2C_BYTE_W-1];
      end
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_v;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = (byte_v[I2C_BYTE_W-1:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = byte_v;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (int'(byte_v) < NUM_REGS) begin
                reg_ptr_d = PW'(byte_v);
                state_d   = ST_PTR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_v;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              wr_stb_d  = 1'b1;
              wr_data_d = byte_v;
              state_d   = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd9;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK) begin
                if (shift_q[0]) begin
                  rd_stb_d = 1'b1;
                  state_d  = ST_RDATA;
                end else begin
                  state_d = ST_PTR;
                end
              end else if (state_q == ST_PTR_ACK) begin
                state_d = ST_WDATA;
              end else begin
                reg_ptr_d = ptr_next;
                state_d   = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[I2C_BYTE_W-2];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_f;
          end
          if (scl_fall) begin
            if (!ack_q) begin
              reg_ptr_d = ptr_next;
              rd_stb_d  = 1'b1;
              state_d   = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.sda_oe    = sda_oe_q;
    bus.reg_ptr   = reg_ptr_q;
    bus.wr_stb    = wr_stb_q;
    bus.wr_data   = wr_data_q;
    bus.rd_stb    = rd_stb_q;
    bus.start_det = start_det_q;
    bus.stop_det  = stop_det_q;
    bus.busy      = busy_q;
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench for the I2C target register window
// Bit-banged master with open-drain SDA; user storage answers reads with {ptr, ~ptr}.
module tb_i2c_target_regs;

  localparam int Q = 16;

  logic clk100 = 1'b0;
  logic reset_n;
  logic scl_m;
  logic sda_m;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  int n_stop   = 0;
  int n_oe     = 0;
  logic [3:0] wr_ptr_log[$];
  logic [7:0] wr_dat_log[$];
  logic [3:0] rd_ptr_log[$];

  i2c_target_regs_if #(.PW(4)) bus ();

  i2c_target_regs #(
    .TARGET_ADDR (7'h42),
    .NUM_REGS    (16),
    .FILTER_LEN  (4)
  ) dut (
    .clk100  (clk100),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk100 = ~clk100;

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  always @(posedge clk100) begin
    if (bus.rd_stb) bus.rd_data <= {bus.reg_ptr, ~bus.reg_ptr};
  end

  always @(negedge clk100) begin
    if (bus.wr_stb) begin
      wr_ptr_log.push_back(bus.reg_ptr);
      wr_dat_log.push_back(bus.wr_data);
    end
    if (bus.rd_stb) rd_ptr_log.push_back(bus.reg_ptr);
    if (bus.start_det) n_start++;
    if (bus.stop_det) n_stop++;
    if (bus.sda_oe) n_oe++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(Q); sda_m = b;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(2*Q); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(Q); sda_m = 1'b1;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(Q); b = bus.sda_i;
    wait_cyc(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic i2c_start();
    scl_m = 1'b0;
    wait_cyc(Q); sda_m = 1'b1;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(Q); sda_m = 1'b0;
    wait_cyc(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(Q); sda_m = 1'b0;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(Q); sda_m = 1'b1;
    wait_cyc(Q);
  endtask

  initial begin
    repeat (80000) @(posedge clk100);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int b_wr, b_rd, b_start, b_stop, b_oe;

    reset_n = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(5);
    chk("reset_outputs", 32'({bus.sda_oe, bus.reg_ptr, bus.wr_stb, bus.wr_data, bus.rd_stb,
                              bus.start_det, bus.stop_det, bus.busy}), 32'h0);

    // Two-byte write starting at register 3
    b_wr = wr_ptr_log.size(); b_start = n_start; b_stop = n_stop;
    i2c_start();
    send_byte(8'h84, ack); chk("t1_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h03, ack); chk("t1_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'hA5, ack); chk("t1_d0_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, ack); chk("t1_d1_ack", 32'(ack), 32'd0);
    chk("t1_busy_mid", 32'(bus.busy), 32'd1);
    i2c_stop();
    wait_cyc(20);
    chk("t1_wr_count", 32'(wr_ptr_log.size() - b_wr), 32'd2);
    chk("t1_wr0_ptr", 32'(wr_ptr_log[b_wr]), 32'd3);
    chk("t1_wr0_data", 32'(wr_dat_log[b_wr]), 32'hA5);
    chk("t1_wr1_ptr", 32'(wr_ptr_log[b_wr+1]), 32'd4);
    chk("t1_wr1_data", 32'(wr_dat_log[b_wr+1]), 32'h5A);
    chk("t1_reg_ptr", 32'(bus.reg_ptr), 32'd5);
    chk("t1_start_cnt", 32'(n_start - b_start), 32'd1);
    chk("t1_stop_cnt", 32'(n_stop - b_stop), 32'd1);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);

    // Pointer 15, repeated START, three-byte read wrapping through 0
    b_rd = rd_ptr_log.size(); b_start = n_start;
    i2c_start();
    send_byte(8'h84, ack); chk("t2_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h0F, ack); chk("t2_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h85, ack); chk("t2_raddr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, d); chk("t2_rd0", 32'(d), 32'hF0);
    read_byte(1'b0, d); chk("t2_rd1", 32'(d), 32'h0F);
    read_byte(1'b1, d); chk("t2_rd2", 32'(d), 32'h1E);
    i2c_stop();
    wait_cyc(20);
    chk("t2_rd_count", 32'(rd_ptr_log.size() - b_rd), 32'd3);
    chk("t2_rd0_ptr", 32'(rd_ptr_log[b_rd]), 32'd15);
    chk("t2_rd1_ptr", 32'(rd_ptr_log[b_rd+1]), 32'd0);
    chk("t2_rd2_ptr", 32'(rd_ptr_log[b_rd+2]), 32'd1);
    chk("t2_start_cnt", 32'(n_start - b_start), 32'd2);
    chk("t2_reg_ptr", 32'(bus.reg_ptr), 32'd1);

    // Foreign address: no drive at all, busy still tracks the bus
    b_oe = n_oe;
    i2c_start();
    send_byte(8'h86, ack); chk("t3_addr_nack", 32'(ack), 32'd1);
    chk("t3_busy_mid", 32'(bus.busy), 32'd1);
    send_byte(8'h12, ack); chk("t3_data_nack", 32'(ack), 32'd1);
    chk("t3_busy_mid2", 32'(bus.busy), 32'd1);
    i2c_stop();
    wait_cyc(20);
    chk("t3_oe_cycles", 32'(n_oe - b_oe), 32'd0);
    chk("t3_busy_end", 32'(bus.busy), 32'd0);

    // Out-of-range pointer is NACKed and the following data ignored
    b_wr = wr_ptr_log.size();
    i2c_start();
    send_byte(8'h84, ack); chk("t4_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h10, ack); chk("t4_ptr_nack", 32'(ack), 32'd1);
    send_byte(8'h77, ack); chk("t4_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    wait_cyc(20);
    chk("t4_reg_ptr", 32'(bus.reg_ptr), 32'd1);
    chk("t4_wr_count", 32'(wr_ptr_log.size() - b_wr), 32'd0);

    // Short SDA glitches while SCL is high must not register as START/STOP
    b_start = n_start; b_stop = n_stop;
    sda_m = 1'b0; wait_cyc(2); sda_m = 1'b1; wait_cyc(20);
    sda_m = 1'b0; wait_cyc(3); sda_m = 1'b1; wait_cyc(20);
    chk("t5_start_cnt", 32'(n_start - b_start), 32'd0);
    chk("t5_stop_cnt", 32'(n_stop - b_stop), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);

    // Reset asserted while the target drives a read bit
    i2c_start();
    send_byte(8'h84, ack); chk("t6_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h00, ack); chk("t6_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h85, ack); chk("t6_raddr_ack", 32'(ack), 32'd0);
    wait_cyc(20);
    chk("t6_oe_before_reset", 32'(bus.sda_oe), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("t6_oe_async_release", 32'(bus.sda_oe), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(20);
    chk("t6_reg_ptr_reset", 32'(bus.reg_ptr), 32'd0);
    chk("t6_busy_reset", 32'(bus.busy), 32'd0);
    b_wr = wr_ptr_log.size();
    i2c_start();
    send_byte(8'h84, ack); chk("t6b_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h02, ack); chk("t6b_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h99, ack); chk("t6b_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_cyc(20);
    chk("t6b_wr_count", 32'(wr_ptr_log.size() - b_wr), 32'd1);
    chk("t6b_wr_ptr", 32'(wr_ptr_log[b_wr]), 32'd2);
    chk("t6b_wr_data", 32'(wr_dat_log[b_wr]), 32'h99);
    chk("t6b_reg_ptr", 32'(bus.reg_ptr), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Parametrised I2C target (slave) with a byte-wide register window: oversamples SCL/SDA on `clk100`, decodes START, repeated START and STOP, matches a configurable 7-bit address, and supports pointer-based multi-byte writes and reads with auto-increment. It is the next generation of the address-only ACK block and sits between the board-level open-drain pins and user logic, which owns the register storage.

## Interface
- `TARGET_ADDR`, 7'h42, 7-bit address this target acknowledges
- `NUM_REGS`, 16, number of byte registers addressable (≥2; pointer width `PW = $clog2(NUM_REGS)`)
- `FILTER_LEN`, 4, consecutive equal `clk100` samples required to accept a new SCL/SDA level
- `clk100`  in  1  system clock, 100 MHz; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `scl_i`  in  1  raw SCL pin level (asynchronous)
- `sda_i`  in  1  raw SDA pin level (asynchronous)
- `sda_oe`  out  1  1 = pull SDA low; pin tristate otherwise
- `reg_ptr`  out  PW  current register pointer
- `wr_stb`  out  1  one-cycle pulse: `wr_data` to be written at `reg_ptr`
- `wr_data`  out  8  received data byte
- `rd_stb`  out  1  one-cycle pulse: user must present byte for `reg_ptr` on `rd_data` next cycle
- `rd_data`  in  8  read data, sampled exactly 1 cycle after `rd_stb`
- `start_det`  out  1  one-cycle pulse per START or repeated START
- `stop_det`  out  1  one-cycle pulse per STOP
- `busy`  out  1  high from START to STOP (any address)

## Operation
- Input path: 2-flop synchroniser per line, then saturating counter filter of `FILTER_LEN`; edges derived from filtered `scl_f`/`sda_f` only.
- START: `sda_f` falls while `scl_f` high → `start_det`, bit counter cleared, state ADDR; valid from any state (repeated START). STOP: `sda_f` rises while `scl_f` high → `stop_det`, state IDLE, `sda_oe` = 0.
- Data bits sampled on `scl_f` rising edge; `sda_oe` changes only on `scl_f` falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits MSB first; on 8th bit compare upper 7 to `TARGET_ADDR`. Mismatch → IGNORE (no drive until START/STOP). Match → ADDR_ACK (drive low for the 9th clock).
- After ADDR_ACK: R/W=0 → PTR; R/W=1 → `rd_stb`, load shift register from `rd_data`, RDATA.
- PTR: byte < `NUM_REGS` → `reg_ptr` = byte, ACK, WDATA; else NACK (release), IGNORE, `reg_ptr` unchanged.
- WDATA: after 8th bit, `wr_stb` with `wr_data`, ACK, then `reg_ptr` increments mod `NUM_REGS`.
- RDATA: drive `sda_oe` = ~bit for 8 bits, release for RDATA_ACK, sample master ACK. ACK(0) → `reg_ptr` +1 mod `NUM_REGS`, `rd_stb`, RDATA; NACK(1) → IGNORE.
- `reg_ptr` persists across transactions (read after write-pointer-only transaction reads that register).

## Timing
- Reset: `sda_oe`=0, `reg_ptr`=0, `wr_stb`=0, `wr_data`=0, `rd_stb`=0, `start_det`=0, `stop_det`=0, `busy`=0, state IDLE, filters preset to 1 (bus idle).
- Pin-to-filtered latency: 2 + `FILTER_LEN` cycles; event pulses 1 cycle after filtered edge.
- `sda_oe` update: 1 cycle after filtered SCL falling edge (hold time ≥ (3+`FILTER_LEN`)·10 ns).
- `wr_stb`: 1 cycle after the 8th rising SCL of the data byte; `reg_ptr` increments on the ACK-clock falling edge.
- `rd_stb`: on the falling SCL that ends the ACK bit; `rd_data` captured next cycle; first bit driven that cycle + 1.
- Reset mid-transfer: SDA released within the reset assertion (asynchronous); after release, IDLE until next START.
- START and STOP never coincide (same filtered SDA edge); a STOP during ACK releases SDA immediately.

## Structure
- Package `i2c_pkg`: `i2c_state_t` enum, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8.
- Sub-module `i2c_line_filter` (sync + glitch filter + rise/fall pulses), instantiated twice.

## Test plan
- Write 8'h84 addr, ptr 8'h03, data 8'hA5, 8'h5A, STOP → ACK ×4, `wr_stb` at ptr 3 then 4, `reg_ptr`=5, `stop_det` one pulse.
- Write ptr 8'h0F, repeated START, 8'h85, read 3 bytes (ACK, ACK, NACK) → `rd_stb` at ptr 15, 0, 1 (wrap), SDA shows `rd_data` bits MSB first.
- Address 8'h86 → NACK, `sda_oe` never asserted until STOP, `busy` high throughout.
- Ptr 8'h10 with `NUM_REGS`=16 → NACK, `reg_ptr` unchanged, subsequent data bytes ignored.
- 2-cycle SDA glitch while SCL high (`FILTER_LEN`=4) → no `start_det`/`stop_det`.
- Assert `reset_n` low during RDATA with `sda_oe`=1 → `sda_oe`=0 immediately; next valid transaction ACKed normally.
